// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader, fetch and decode.
package imem_loader_pkg;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSEMBLE = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU hold/status for the loader.
interface imem_loader_if #(parameter int ADDR_WIDTH = 6);
    import imem_loader_pkg::*;

    logic                  start;
    logic [ADDR_WIDTH:0]   load_len;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [INSTR_W-1:0]    imem_wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  err;

    modport master (
        output start, load_len, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
    );

    modport slave (
        input  start, load_len, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: first pushed byte lands in the MSB.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word_nxt,
    output logic               full
);
    logic [1:0]         idx;
    logic [INSTR_W-1:0] word;

    // word_nxt already contains the byte being pushed, so the 4th push can
    // hand a complete word to the loader on the same edge.
    always_comb begin
        word_nxt = word;
        word_nxt[INSTR_W-1-8*idx -: 8] = byte_in;
    end

    assign full = push && (idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= 2'd0;
            word <= '0;
        end else if (clear) begin
            idx <= 2'd0;
        end else if (push) begin
            idx  <= idx + 2'd1;
            word <= word_nxt;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory from address 0, holding the CPU until complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic          Clock,
    input  logic          Reset,
    imem_loader_if.slave  bus
);
    localparam int                  DEPTH   = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    state_t              state;
    logic [ADDR_WIDTH:0] len;
    logic [ADDR_WIDTH:0] count;
    logic [INSTR_W-1:0]  pk_word;
    logic                pk_full;
    logic                pk_push;
    logic                pk_clear;

    assign pk_push  = (state == ST_ASSEMBLE) && bus.in_valid && bus.in_ready;
    assign pk_clear = (state != ST_ASSEMBLE);

    byte_packer u_packer (
        .clk      (Clock),
        .rst      (Reset),
        .clear    (pk_clear),
        .push     (pk_push),
        .byte_in  (bus.in_data),
        .word_nxt (pk_word),
        .full     (pk_full)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state          <= ST_IDLE;
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            bus.cpu_hold   <= 1'b1;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            len            <= '0;
            count          <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        if (bus.load_len > DEPTH_L) begin
                            bus.err <= 1'b1;
                        end else if (bus.load_len == '0) begin
                            bus.err      <= 1'b0;
                            bus.done     <= 1'b1;
                            bus.cpu_hold <= 1'b0;
                            state        <= ST_DONE;
                        end else begin
                            bus.err       <= 1'b0;
                            bus.done      <= 1'b0;
                            bus.cpu_hold  <= 1'b1;
                            bus.imem_addr <= '0;
                            bus.in_ready  <= 1'b1;
                            count         <= '0;
                            len           <= bus.load_len;
                            state         <= ST_ASSEMBLE;
                        end
                    end
                end
                ST_ASSEMBLE: begin
                    if (pk_full) begin
                        bus.in_ready   <= 1'b0;
                        bus.imem_we    <= 1'b1;
                        bus.imem_wdata <= pk_word;
                        state          <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    count <= count + 1'b1;
                    // The address is left on the last word so a full-depth load never wraps.
                    if (count + 1'b1 == len) begin
                        bus.done     <= 1'b1;
                        bus.cpu_hold <= 1'b0;
                        state        <= ST_DONE;
                    end else begin
                        bus.imem_addr <= bus.imem_addr + 1'b1;
                        bus.in_ready  <= 1'b1;
                        state         <= ST_ASSEMBLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Randomised loader bench: a reference write list is queued per load and a monitor checks every strobe.
module tb_imem_loader;
    localparam int AW    = 6;
    localparam int DEPTH = 2**AW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus();
    imem_loader #(.ADDR_WIDTH(AW)) dut (.Clock(clk), .Reset(rst), .bus(bus));

    int    errors = 0;
    int    checks = 0;
    wr_t   expq[$];
    logic [31:0] wl[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Every write strobe must match the next expected (addr, data) pair.
    always @(negedge clk) begin
        wr_t e;
        if (bus.imem_we === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h want no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                e = expq.pop_front();
                chk("wr_addr", bus.imem_addr, e.addr);
                chk("wr_data", bus.imem_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_we", bus.imem_we, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_hold", bus.cpu_hold, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 40; t++) begin
            r = bus.in_ready;
            tick();
            if (r) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL byte_accept_timeout: got no in_ready within 40 cycles want accept");
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [AW:0] n);
        bus.start    = 1'b1;
        bus.load_len = n;
        tick();
        bus.start    = 1'b0;
    endtask

    // gapmode: 0 back-to-back, 1 one idle cycle before every byte, 2 random gaps.
    task automatic run_load(input int gapmode, input bit mid_start);
        int          n;
        int          gap;
        logic [31:0] w;
        n = wl.size();
        for (int i = 0; i < n; i++) expq.push_back(wr_t'{AW'(i), wl[i]});
        do_start((AW+1)'(n));
        chk("start_in_ready", bus.in_ready, 1);
        chk("start_done_low", bus.done, 0);
        chk("start_hold_high", bus.cpu_hold, 1);
        chk("start_err_low", bus.err, 0);
        for (int i = 0; i < n; i++) begin
            w = wl[i];
            for (int j = 0; j < 4; j++) begin
                gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
                if (mid_start && i == 0 && j == 1) begin
                    bus.start    = 1'b1;
                    bus.load_len = 1;
                end
                send_byte(w[31-8*j -: 8], gap);
                bus.start = 1'b0;
            end
            chk("write_cycle_we", bus.imem_we, 1);
            chk("write_cycle_ready", bus.in_ready, 0);
            if (i == n-1) begin
                chk("last_write_done_low", bus.done, 0);
                chk("last_write_hold_high", bus.cpu_hold, 1);
            end
        end
        tick();
        chk("done_set", bus.done, 1);
        chk("hold_released", bus.cpu_hold, 0);
        chk("done_ready_low", bus.in_ready, 0);
        chk("writes_pending", expq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.load_len = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) tick();
        check_reset_vals();
        rst = 1'b0;
        repeat (2) tick();
        check_reset_vals();

        wl = '{32'h8C01000D, 32'h1000FFFE};
        run_load(0, 1'b0);
        run_load(1, 1'b0);

        wl = '{$urandom(), $urandom(), $urandom()};
        run_load(0, 1'b1);

        do_start(0);
        chk("len0_done", bus.done, 1);
        chk("len0_hold", bus.cpu_hold, 0);
        chk("len0_err", bus.err, 0);
        chk("len0_ready", bus.in_ready, 0);
        repeat (3) tick();

        do_start((AW+1)'(DEPTH+1));
        chk("err_in_done", bus.err, 1);
        chk("err_done_kept", bus.done, 1);
        chk("err_hold_kept", bus.cpu_hold, 0);

        rst = 1'b1;
        #1;
        check_reset_vals();
        tick();
        rst = 1'b0;
        tick();

        do_start((AW+1)'(DEPTH+1));
        chk("err_set", bus.err, 1);
        chk("err_done_low", bus.done, 0);
        chk("err_hold_high", bus.cpu_hold, 1);
        repeat (3) tick();
        chk("err_stays_idle", bus.in_ready, 0);

        wl.delete();
        for (int i = 0; i < DEPTH; i++) wl.push_back(32'hA500_0000 + i);
        run_load(0, 1'b0);
        repeat (3) tick();

        // Abort partway through the first word; nothing must be written.
        do_start(2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 rst = 1'b1;
        #1;
        check_reset_vals();
        tick();
        rst = 1'b0;
        tick();
        wl = '{32'h33445566, 32'h778899AA};
        run_load(2, 1'b0);

        for (int k = 0; k < 5; k++) begin
            wl.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) wl.push_back($urandom());
            run_load(2, 1'b0);
        end

        repeat (3) tick();
        chk("final_queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that sits on the write side of the instruction memory read by the instruction-fetch stage. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes them to consecutive instruction-memory addresses starting at 0. The CPU is held off (`cpu_hold`) until the programme is complete, so fetch never observes a partially written memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 6: instruction-memory word-address width; depth `DEPTH = 2**ADDR_WIDTH` words.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `Clock`  in  1: sole clock, all state updates on rising edge.
- `Reset`  in  1: asynchronous, active-high.
- `start`  in  1: single-cycle load request, sampled only in IDLE or DONE.
- `load_len`  in  ADDR_WIDTH+1: number of words to load, sampled with `start`.
- `in_valid`  in  1: byte present on `in_data`.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `imem_we`  out  1: instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_WIDTH: word address of the write.
- `imem_wdata`  out  32: word to write.
- `cpu_hold`  out  1: keeps the CPU's PC in reset while high.
- `done`  out  1: load complete, level.
- `err`  out  1: last `start` rejected (`load_len > DEPTH`), level.

## Operation
- FSM states: IDLE, ASSEMBLE, WRITE, DONE.
- Reset values:
  - state=IDLE.
  - `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_hold`=1, `done`=0, `err`=0.
  - byte index=0, word count=0.
- IDLE or DONE, `start`=1:
  - `load_len > DEPTH`: `err`<=1; state, `done` and `cpu_hold` are unchanged.
  - `load_len == 0`: `err`<=0, state<=DONE, `done`<=1, `cpu_hold`<=0, no writes.
  - otherwise: `err`<=0, `done`<=0, `cpu_hold`<=1, addr<=0, count<=0, byte index<=0, state<=ASSEMBLE.
- ASSEMBLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, the byte goes to `word[31-8*idx -: 8]` (first byte is MSB) and idx increments.
  - When the 4th byte is accepted, go to WRITE.
- WRITE: one cycle.
  - `imem_we`=1, `in_ready`=0, `imem_wdata` = the assembled word, `imem_addr` = current addr.
  - Next cycle: addr+1 and count+1.
  - If count+1 == len: go to DONE and set `done`=1, `cpu_hold`=0. Otherwise return to ASSEMBLE with idx=0.
- DONE: hold outputs until a new `start`; a new `start` reloads from address 0.
- `start` in ASSEMBLE or WRITE: ignored.
- `in_valid` outside ASSEMBLE: ignored; `in_ready`=0, nothing consumed.
- Address never wraps: `load_len <= DEPTH` is guaranteed by the `err` check. A `load_len == DEPTH` load ends with the write to `DEPTH-1`.

## Timing
- `in_ready` is a registered function of state; it is high in every ASSEMBLE cycle, including the cycle the 4th byte is taken.
- Byte accept happens on the rising edge where `in_valid && in_ready`. With a back-to-back stream, one word takes 4 accept cycles plus 1 WRITE cycle (5 cycles/word).
- `imem_we` is high for exactly 1 cycle per word. Address and data are stable that cycle; the memory captures on the same rising edge.
- `cpu_hold` falls and `done` rises on the edge leaving the last WRITE cycle. The CPU fetches address 0 no earlier than the next edge.
- `start` to first `in_ready`=1: 1 cycle.
- Reset asserted mid-load: immediate return to reset values. The partial word is discarded, `cpu_hold`=1, and the memory keeps whatever was already written.

## Structure
- Shared package: the state enum (IDLE/ASSEMBLE/WRITE/DONE encodings) and the instruction word width constant (32), reused by fetch and decode.
- One natural sub-module, `byte_packer`: 2-bit index plus 32-bit shift/insert register, with `clear`, `push`, and a `full` pulse. The FSM, address/count counters and output registers stay in `imem_loader`.

## Test plan
- Reset then `start` with `load_len`=2 and bytes 8C,01,00,0D,10,00,FF,FE → two `imem_we` pulses: addr 0 data 0x8C01000D, then addr 1 data 0x1000FFFE. `done`=1 and `cpu_hold`=0 one cycle after the second pulse.
- Same load with `in_valid` toggled off every other cycle → identical writes; no byte lost or duplicated; 5th byte not consumed before the first WRITE completes.
- `load_len`=0 → `done`=1, `cpu_hold`=0 next cycle, no `imem_we`. `load_len`=DEPTH+1 → `err`=1, stays IDLE, `cpu_hold`=1.
- `load_len`=DEPTH with incrementing words → last write at addr DEPTH-1, no wrap to 0, then DONE.
- `Reset` pulsed after 2 bytes of word 1 → all outputs at reset values asynchronously. A new `start` reloads starting at addr 0 with the byte index cleared.
- `start` asserted during ASSEMBLE → ignored, load continues. `start` in DONE → `done` clears, `cpu_hold` reasserts, addr restarts at 0.
